serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder built around the existing `full_adder` cell (ports: sum, cout, a, b, cin). It captures two operands and a carry-in on a start request, feeds the single `full_adder` one bit pair per clock (LSB first) with a registered carry, and presents the WIDTH-bit sum and carry-out with a one-cycle done pulse. It is the sequential stage that drives the full-adder bit-slice, trading latency for area in front of the lab datapath.

---
 rtl/serial_adder.sv | 147 ++++++++++++++
 tb/tb_serial_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around one full_adder cell.
// A start request in IDLE captures a, b and cin; one bit pair is added per
// clock, LSB first, with the carry held in a flop. The result lands in
// sum/cout together with a one-cycle done pulse, WIDTH+1 cycles after the
// start edge, and is held until the next operation completes.
//
// Ports:
//   clk    sole clock, rising edge
//   rst    asynchronous active-high reset
//   start  request, sampled only in IDLE
//   a, b   WIDTH-bit operands, captured on accepted start
//   cin    carry-in, captured on accepted start
//   busy   high while not IDLE (BUSY or DONE)
//   done   one-cycle pulse, sum/cout valid
//   sum    registered WIDTH-bit result
//   cout   registered carry-out
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; sum/cout hold the previous result
// BUSY  | one bit pair per edge through the full_adder, LSB first
// DONE  | result registered, done asserted for this single cycle

module full_adder (
   output logic sum,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic cin
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] s_sh_q, s_sh_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic fa_sum;
   logic fa_cout;

   full_adder u_fa (
      .sum  (fa_sum),
      .cout (fa_cout),
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q)
   );

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      s_sh_d  = s_sh_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               s_sh_d  = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
            s_sh_d  = {fa_sum, s_sh_q[WIDTH-1:1]};
            carry_d = fa_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               // final bit: the shifted-in sum bit completes the result
               sum_d   = {fa_sum, s_sh_q[WIDTH-1:1]};
               cout_d  = fa_cout;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         s_sh_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         s_sh_q  <= s_sh_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start8 = 1'b0;
   logic        start16 = 1'b0;
   logic [15:0] a_drv = '0;
   logic [15:0] b_drv = '0;
   logic        cin_drv = 1'b0;

   logic        busy8, done8, cout8;
   logic [7:0]  sum8;
   logic        busy16, done16, cout16;
   logic [15:0] sum16;

   logic        sel16 = 1'b0;
   logic        busy_m, done_m, cout_m;
   logic [15:0] sum_m;

   int passed = 0;
   int total  = 0;
   logic [15:0] prev_sum [2];
   logic        prev_cout [2];

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .a     (a_drv[7:0]),
      .b     (b_drv[7:0]),
      .cin   (cin_drv),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8)
   );

   serial_adder #(.WIDTH(16)) dut16 (
      .clk   (clk),
      .rst   (rst),
      .start (start16),
      .a     (a_drv),
      .b     (b_drv),
      .cin   (cin_drv),
      .busy  (busy16),
      .done  (done16),
      .sum   (sum16),
      .cout  (cout16)
   );

   assign busy_m = sel16 ? busy16 : busy8;
   assign done_m = sel16 ? done16 : done8;
   assign cout_m = sel16 ? cout16 : cout8;
   assign sum_m  = sel16 ? sum16  : {8'h00, sum8};

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       co;
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else
         passed++;
   endtask

   // Reference: plain integer addition, split into carry-out and sum.
   task automatic model(input int w, input logic [15:0] ta, input logic [15:0] tbv,
                        input logic tc, output logic [15:0] es, output logic ec);
      longint unsigned tot;
      tot = longint'(ta) + longint'(tbv) + longint'(tc);
      es  = 16'(tot & ((64'd1 << w) - 1));
      ec  = tot[w];
   endtask

   // Wait (bounded) for done; cyc counts negedges since the start edge.
   task automatic wait_done(input int w, output int cyc, output bit stable);
      int idx;
      idx    = (w == 16) ? 1 : 0;
      cyc    = 1;
      stable = 1'b1;
      while (!done_m && cyc < 64) begin
         if (sum_m !== prev_sum[idx] || cout_m !== prev_cout[idx]) stable = 1'b0;
         @(negedge clk);
         cyc++;
      end
   endtask

   // Called at a negedge with the selected DUT idle; leaves it idle at a negedge.
   task automatic op(input int w, input logic [15:0] ta, input logic [15:0] tbv,
                     input logic tc, input logic [15:0] es, input logic ec, input string nm);
      int cyc;
      bit stable;
      int idx;
      idx     = (w == 16) ? 1 : 0;
      sel16   = (w == 16);
      a_drv   = ta;
      b_drv   = tbv;
      cin_drv = tc;
      if (w == 16) start16 = 1'b1; else start8 = 1'b1;
      @(negedge clk);
      start8  = 1'b0;
      start16 = 1'b0;
      a_drv   = 16'($urandom);
      b_drv   = 16'($urandom);
      chk({nm, " busy_after_start"}, 32'(busy_m), 32'd1);
      wait_done(w, cyc, stable);
      chk({nm, " latency"}, 32'(cyc), 32'(w + 1));
      chk({nm, " stable_until_done"}, 32'(stable), 32'd1);
      chk({nm, " sum"}, 32'(sum_m), 32'(es));
      chk({nm, " cout"}, 32'(cout_m), 32'(ec));
      chk({nm, " busy_in_done"}, 32'(busy_m), 32'd1);
      prev_sum[idx]  = es;
      prev_cout[idx] = ec;
      @(negedge clk);
      chk({nm, " done_pulse_end"}, 32'(done_m), 32'd0);
      chk({nm, " idle_busy_low"}, 32'(busy_m), 32'd0);
   endtask

   initial begin
      logic [15:0] ra, rb, es;
      logic        rc, ec;
      int          cyc;
      bit          stable;
      bit          any_done;

      vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, s: 8'h96, co: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, co: 1'b1};
      vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, co: 1'b1};
      vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, s: 8'h01, co: 1'b0};
      prev_sum[0] = '0; prev_sum[1] = '0;
      prev_cout[0] = 1'b0; prev_cout[1] = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst sum8", 32'(sum8), 32'd0);
      chk("rst cout8", 32'(cout8), 32'd0);
      chk("rst busy8", 32'(busy8), 32'd0);
      chk("rst done8", 32'(done8), 32'd0);
      chk("rst busy16", 32'(busy16), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++)
         op(8, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].cin,
            {8'h00, vecs[i].s}, vecs[i].co, $sformatf("vec%0d", i));

      // start held high with changing operands through BUSY and DONE
      sel16   = 1'b0;
      a_drv   = 16'h0012;
      b_drv   = 16'h0034;
      cin_drv = 1'b0;
      start8  = 1'b1;
      @(negedge clk);
      a_drv = 16'h00FF;
      b_drv = 16'h00FF;
      wait_done(8, cyc, stable);
      chk("hold latency1", 32'(cyc), 32'd9);
      chk("hold sum1", 32'(sum8), 32'h46);
      chk("hold cout1", 32'(cout8), 32'd0);
      @(negedge clk);
      chk("hold idle_gap", 32'(busy8), 32'd0);
      @(negedge clk);
      start8 = 1'b0;
      chk("hold second_accept", 32'(busy8), 32'd1);
      prev_sum[0] = 16'h0046; prev_cout[0] = 1'b0;
      wait_done(8, cyc, stable);
      chk("hold latency2", 32'(cyc), 32'd9);
      chk("hold stable2", 32'(stable), 32'd1);
      chk("hold sum2", 32'(sum8), 32'hFE);
      chk("hold cout2", 32'(cout8), 32'd1);
      prev_sum[0] = 16'h00FE; prev_cout[0] = 1'b1;
      @(negedge clk);

      // reset in the middle of an operation
      op(8, 16'h5A, 16'h3C, 1'b0, 16'h96, 1'b0, "pre_rst");
      a_drv = 16'h0001; b_drv = 16'h0001; cin_drv = 1'b0;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst sum", 32'(sum8), 32'd0);
      chk("async_rst cout", 32'(cout8), 32'd0);
      chk("async_rst busy", 32'(busy8), 32'd0);
      chk("async_rst done", 32'(done8), 32'd0);
      any_done = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done8) any_done = 1'b1;
      end
      chk("no_done_after_rst", 32'(any_done), 32'd0);
      prev_sum[0] = '0; prev_cout[0] = 1'b0;
      prev_sum[1] = '0; prev_cout[1] = 1'b0;
      op(8, 16'h10, 16'h20, 1'b0, 16'h30, 1'b0, "post_rst");

      // randomized back-to-back operations, both widths
      for (int w = 8; w <= 16; w += 8) begin
         for (int n = 0; n < 1000; n++) begin
            ra = (w == 8) ? {8'h00, 8'($urandom)} : 16'($urandom);
            rb = (w == 8) ? {8'h00, 8'($urandom)} : 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            model(w, ra, rb, rc, es, ec);
            op(w, ra, rb, rc, es, ec, $sformatf("rand%0d_%0d", w, n));
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
